// File: rtl/dio_status_reporter.sv
// rtl/dio_status_reporter.sv - polls DIO sticky status, keeps saturating error stats, streams an 18-word report
// Optional auto-report after AUTO_REPORT_POLLS polls: define DIO_STATUS_AUTO_REPORT_EN.
module dio_status_reporter #(
    parameter int POLL_PERIOD       = 100000,
    parameter int CNT_WIDTH         = 16,
    parameter int AUTO_REPORT_POLLS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dio_counter_status_tdata,
    input  logic        dio_counter_status_tvalid,
    output logic        dio_counter_status_tready,
    input  logic [7:0]  cmd_tdata,
    input  logic        cmd_tvalid,
    output logic        cmd_tready,
    output logic [31:0] report_tdata,
    output logic        report_tvalid,
    input  logic        report_tready,
    output logic        report_tlast
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_CH, S_SUM} state_t;

    localparam int TW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [TW-1:0]        TIMER_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t               state;
    logic [3:0]           ch;
    logic [TW-1:0]        timer;
    logic [31:0]          poll_count;
    logic [CNT_WIDTH-1:0] err_count [16];
    logic [15:0]          fail_mask;
    logic                 not_running_seen;
    logic                 config_err_seen;
    logic                 clear_after;

    logic poll_hs, cmd_hs, report_hs, start_report, clear_now;

    logic unused_inputs;
    assign unused_inputs = ^{cmd_tdata[7:2], dio_counter_status_tdata[31:18]};

    assign dio_counter_status_tready = (state == S_IDLE) && (timer == TIMER_LAST)
                                       && dio_counter_status_tvalid;
    assign poll_hs    = dio_counter_status_tready;
    assign cmd_tready = (state == S_IDLE);
    assign cmd_hs     = cmd_tvalid && cmd_tready;
    assign report_hs  = report_tvalid && report_tready;
    // Clear-only beats a coincident poll; report-then-clear fires on the final word handshake.
    assign clear_now  = (cmd_hs && !cmd_tdata[0] && cmd_tdata[1])
                        || (state == S_SUM && report_hs && clear_after);

`ifdef DIO_STATUS_AUTO_REPORT_EN
    logic [31:0] auto_cnt;
    logic        auto_fire;

    assign auto_fire    = (state == S_IDLE) && (auto_cnt >= 32'(AUTO_REPORT_POLLS));
    assign start_report = cmd_hs ? cmd_tdata[0] : auto_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_cnt <= '0;
        end else if (auto_fire) begin
            auto_cnt <= poll_hs ? 32'd1 : 32'd0;
        end else if (poll_hs && auto_cnt != 32'hFFFF_FFFF) begin
            auto_cnt <= auto_cnt + 32'd1;
        end
    end
`else
    localparam int unused_auto_polls = AUTO_REPORT_POLLS;
    assign start_report = cmd_hs && cmd_tdata[0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            if (poll_hs)
                timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_now) begin
            poll_count       <= '0;
            fail_mask        <= '0;
            not_running_seen <= 1'b0;
            config_err_seen  <= 1'b0;
            for (int j = 0; j < 16; j++)
                err_count[j] <= '0;
        end else if (poll_hs) begin
            if (poll_count != 32'hFFFF_FFFF)
                poll_count <= poll_count + 32'd1;
            for (int j = 0; j < 16; j++) begin
                if (dio_counter_status_tdata[j]) begin
                    fail_mask[j] <= 1'b1;
                    if (err_count[j] != CNT_MAX)
                        err_count[j] <= err_count[j] + 1'b1;
                end
            end
            if (dio_counter_status_tdata[16])
                not_running_seen <= 1'b1;
            if (dio_counter_status_tdata[17])
                config_err_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ch          <= '0;
            clear_after <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ch <= '0;
                    if (start_report) begin
                        state       <= S_HDR;
                        clear_after <= cmd_hs && cmd_tdata[1];
                    end
                end
                S_HDR: if (report_hs) state <= S_CH;
                S_CH: begin
                    if (report_hs) begin
                        if (ch == 4'd15)
                            state <= S_SUM;
                        else
                            ch <= ch + 4'd1;
                    end
                end
                S_SUM: begin
                    if (report_hs) begin
                        state       <= S_IDLE;
                        clear_after <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Statistics are frozen outside IDLE, so the word mux is a stable snapshot.
    always_comb begin
        report_tdata = '0;
        case (state)
            S_HDR:   report_tdata = poll_count;
            S_CH:    report_tdata = {4'h0, ch, 8'h00, 16'(err_count[ch])};
            S_SUM:   report_tdata = {14'b0, config_err_seen, not_running_seen, fail_mask};
            default: report_tdata = '0;
        endcase
    end

    assign report_tvalid = (state != S_IDLE);
    assign report_tlast  = (state == S_SUM);
endmodule

// File: tb/tb_dio_status_reporter.sv
// tb/tb_dio_status_reporter.sv - directed scoreboard bench for dio_status_reporter
module tb_dio_status_reporter;
    localparam int PP  = 8;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dio_tdata;
    logic        dio_tvalid;
    logic        dio_tready;
    logic [7:0]  cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [31:0] report_tdata;
    logic        report_tvalid;
    logic        report_tready;
    logic        report_tlast;

    dio_status_reporter #(.POLL_PERIOD(PP), .CNT_WIDTH(CW), .AUTO_REPORT_POLLS(4)) dut (
        .clk(clk),
        .reset(reset),
        .dio_counter_status_tdata(dio_tdata),
        .dio_counter_status_tvalid(dio_tvalid),
        .dio_counter_status_tready(dio_tready),
        .cmd_tdata(cmd_tdata),
        .cmd_tvalid(cmd_tvalid),
        .cmd_tready(cmd_tready),
        .report_tdata(report_tdata),
        .report_tvalid(report_tvalid),
        .report_tready(report_tready),
        .report_tlast(report_tlast)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] expq[$];

    logic [31:0] m_poll;
    int          m_cnt[16];
    logic [15:0] m_fail;
    logic        m_nr, m_ce;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_poll = 0; m_fail = 0; m_nr = 0; m_ce = 0;
        for (int j = 0; j < 16; j++) m_cnt[j] = 0;
    endtask

    task automatic model_poll(input logic [31:0] d);
        if (m_poll != 32'hFFFF_FFFF) m_poll = m_poll + 1;
        for (int j = 0; j < 16; j++)
            if (d[j]) begin
                m_fail[j] = 1'b1;
                if (m_cnt[j] < SAT) m_cnt[j]++;
            end
        if (d[16]) m_nr = 1'b1;
        if (d[17]) m_ce = 1'b1;
    endtask

    task automatic cyc();
        if (dio_tready === 1'b1) model_poll(dio_tdata);
        tick();
    endtask

    task automatic wait_polls(input int n);
        int  got = 0;
        logic p;
        for (int k = 0; k < 40 * PP && got < n; k++) begin
            p = (dio_tready === 1'b1);
            cyc();
            if (p) got++;
        end
        chk("poll_wait", got, n);
    endtask

    task automatic push_report();
        logic [7:0] c;
        expq.push_back(m_poll);
        for (int j = 0; j < 16; j++) begin
            c = 8'(j);
            expq.push_back({c, 8'h00, 16'(m_cnt[j])});
        end
        expq.push_back({14'b0, m_ce, m_nr, m_fail});
    endtask

    task automatic do_report(input logic [7:0] cmd, input bit rnd);
        int          nwords = 0;
        bit          done = 0;
        bit          stalled = 0;
        logic [31:0] held = '0;
        logic [31:0] exp;
        logic        rdy;
        chk("cmd_tready_idle", cmd_tready, 1);
        if (dio_tready === 1'b1) model_poll(dio_tdata);
        push_report();
        if (cmd[1]) model_clear();
        cmd_tdata = cmd; cmd_tvalid = 1'b1;
        tick();
        cmd_tvalid = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            chk("poll_deferred", dio_tready, 0);
            chk("report_tvalid", report_tvalid, 1);
            if (stalled) chk("stall_hold", report_tdata, held);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            report_tready = rdy;
            if (rdy) begin
                exp = expq.pop_front();
                chk($sformatf("word%0d", nwords), report_tdata, exp);
                chk($sformatf("tlast%0d", nwords), report_tlast, (expq.size() == 0));
                nwords++;
                stalled = 0;
                if (expq.size() == 0) done = 1;
            end else begin
                stalled = 1;
                held = report_tdata;
            end
            tick();
        end
        report_tready = 1'b0;
        chk("report_words", nwords, 18);
        chk("idle_after_report", cmd_tready, 1);
        chk("tvalid_after_report", report_tvalid, 0);
    endtask

    initial begin
        bit found;
        reset = 1'b1; dio_tdata = 0; dio_tvalid = 1'b1;
        cmd_tdata = 0; cmd_tvalid = 0; report_tready = 0;
        model_clear();
        tick(); tick();
        chk("rst_dio_tready", dio_tready, 0);
        chk("rst_cmd_tready", cmd_tready, 1);
        chk("rst_report_tvalid", report_tvalid, 0);
        chk("rst_report_tlast", report_tlast, 0);
        chk("rst_report_tdata", report_tdata, 0);
        reset = 1'b0;

        // Poll strobe cadence: cycles 7, 15, 23 after reset release.
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("poll_at_%0d", c), dio_tready, ((c % PP) == PP - 1));
            cyc();
        end
        do_report(8'h01, 0);

        dio_tdata = 32'h0000_8001;
        wait_polls(5);
        dio_tdata = 0;
        do_report(8'h01, 0);

        // Saturation at 7, then sticky not-running flag after the bit drops.
        dio_tdata = 32'h0000_0008;
        wait_polls(9);
        dio_tdata = 32'h0001_0000;
        wait_polls(1);
        dio_tdata = 0;
        wait_polls(1);
        do_report(8'h01, 1);

        // Report-then-clear; the follow-up report sees a poll coincident with its command.
        do_report(8'h03, 1);
        do_report(8'h01, 0);

        // Clear-only command landing on a poll carrying bit0.
        dio_tdata = 32'h1;
        found = 0;
        for (int k = 0; k < 4 * PP && !found; k++) begin
            if (dio_tready === 1'b1) begin
                cmd_tdata = 8'h02; cmd_tvalid = 1'b1;
                model_clear();
                tick();
                cmd_tvalid = 1'b0;
                dio_tdata = 0;
                found = 1;
            end else begin
                cyc();
            end
        end
        chk("clear_poll_found", found, 1);
        do_report(8'h01, 0);

        // Reset in the middle of a report.
        dio_tdata = 32'h4;
        wait_polls(2);
        dio_tdata = 0;
        cmd_tdata = 8'h01; cmd_tvalid = 1'b1;
        tick();
        cmd_tvalid = 1'b0;
        report_tready = 1'b1;
        tick(); tick();
        report_tready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_report_tvalid", report_tvalid, 0);
        chk("midrst_cmd_tready", cmd_tready, 1);
        model_clear();
        expq.delete();
        do_report(8'h01, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
